i2c_slv_single_byte: RTL and testbench
======================================

I2C_SLV_SINGLE_BYTE -- requirements
Module: i2c_slv_single_byte

Interface
REQ-001 SHALL have parameter NUM_CLKS_IDLE_TO, default 800: i_clk cycles without an SCL edge mid-transaction before the transaction is abandoned.
REQ-002 SHALL have parameter NUM_CLKS_T_BUF, default 80: i_clk cycles SCL and SDA must both be high before a START is accepted.
REQ-003 SHALL have parameter WIDTH_IDLE_TO, default 10: width of internal counter idle_timer; must hold both NUM_CLKS_IDLE_TO and NUM_CLKS_T_BUF.
REQ-004 SHALL have port i_clk  in  1  system clock; every register on rising edge.
REQ-005 SHALL have port i_rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port i_addr  in  7  own slave address; sampled at address compare.
REQ-007 SHALL have port i_data  in  8  byte returned on read; captured at address ACK.
REQ-008 SHALL have port i_scl  in  1  bus SCL level; asynchronous.
REQ-009 SHALL have port i_sda  in  1  bus SDA level (wired-AND incl. own o_sda); asynchronous.
REQ-010 SHALL have port o_sda  out  1  open-drain SDA drive; 0 = pull low, 1 = release.
REQ-011 SHALL have port o_data  out  8  last byte written by a master to this address.

Function
REQ-012 SHALL pass i_scl and i_sda through 2-flop synchronizers; all edge detection uses the synchronized, registered values.
REQ-013 SHALL detect START (SDA fall while SCL high) and STOP (SDA rise while SCL high); a repeated START at any point restarts the address phase.
REQ-014 SHALL use FSM states: WAIT_FREE, IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-015 WAIT_FREE SHALL count idle_timer while SCL=SDA=1, clearing on either low; at NUM_CLKS_T_BUF go IDLE. IDLE goes ADDR on START.
REQ-016 ADDR SHALL shift 8 bits MSB-first on SCL rising edges: 7 address bits, then R/W (1 = read).
REQ-017 On address != i_addr, the FSM SHALL go to IGNORE and keep o_sda=1 until STOP or START.
REQ-018 On address match, the FSM SHALL drive o_sda=0 after the SCL falling edge ending bit 8, and hold it through the 9th clock high, releasing after the following SCL fall.
REQ-019 Write: WR_DATA SHALL shift 8 bits, then ACK as in REQ-018; o_data SHALL update to the received byte when the ACK is driven.
REQ-020 Read: after the address ACK, the slave SHALL drive i_data MSB-first; each bit changes only after an SCL falling edge; a 1 bit releases SDA.
REQ-021 Read: after bit 0 the slave SHALL release SDA for the master ACK/NACK.
REQ-022 Second and later bytes SHALL NOT be supported: after the first data byte plus ACK cycle, go IGNORE (no ACK on extra write bytes; SDA released on further reads).
REQ-023 STOP in any state SHALL release o_sda and go WAIT_FREE.
REQ-024 In states other than WAIT_FREE/IDLE, idle_timer SHALL count cycles since the last SCL edge; at NUM_CLKS_IDLE_TO, release o_sda and go WAIT_FREE.
REQ-025 o_sda SHALL never change while synchronized SCL is high, except on reset or timeout release.

Reset
REQ-026 On i_rst=1: o_sda=1, o_data=8'h00, idle_timer=0, FSM=WAIT_FREE, shift registers cleared; an in-flight transaction is abandoned without glitching SDA low.

Configuration
REQ-027 Macro I2C_SLV_SINGLE_BYTE_GLITCH_FILTER_EN defined: each synchronized SCL/SDA passes a 3-sample majority filter, adding 2 cycles of latency. Undefined: no filter.

Verification (i_clk 64 ns; SCL low 5000 ns, high 4700 ns; i_addr=7'h51)
REQ-028 Write addr 7'h52, data 8'hAC -> o_sda never low; o_data unchanged (not 8'hAC).
REQ-029 Read addr 7'h52 -> o_sda never low during the whole transaction.
REQ-030 Write addr 7'h51, data 8'h53 -> ACK on both 9th bits; o_data=8'h53 after STOP.
REQ-031 i_data=8'h21, read addr 7'h51, master NACK -> bus bits sampled at SCL rise = 1010001,1,0 then 00100001; SDA released before STOP.
REQ-032 START+addr 7'h51 write, then SCL held low >800 cycles -> o_sda=1, FSM WAIT_FREE; next valid write accepted.
REQ-033 i_rst asserted during the address ACK -> o_sda=1 next cycle, o_data=8'h00.

Source files
------------

// File: rtl/i2c_slv_single_byte.sv
// Single-byte I2C slave: one write byte to o_data or one read byte from i_data per transaction.
// Optional SCL/SDA majority glitch filter: define I2C_SLV_SINGLE_BYTE_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module i2c_slv_single_byte #(
   parameter int unsigned NUM_CLKS_IDLE_TO = 800,
   parameter int unsigned NUM_CLKS_T_BUF   = 80,
   parameter int unsigned WIDTH_IDLE_TO    = 10
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_addr,
   input  logic [7:0] i_data,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda,
   output logic [7:0] o_data
);

   localparam logic [WIDTH_IDLE_TO-1:0] IDLE_TO_C = WIDTH_IDLE_TO'(NUM_CLKS_IDLE_TO);
   localparam logic [WIDTH_IDLE_TO-1:0] T_BUF_C   = WIDTH_IDLE_TO'(NUM_CLKS_T_BUF);

   typedef enum logic [3:0] {
      WAIT_FREE, IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic       scl_s, sda_s;

`ifdef I2C_SLV_SINGLE_BYTE_GLITCH_FILTER_EN
   logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
   logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
`endif

   always_comb begin
      scl_sync_d = {scl_sync_q[0], i_scl};
      sda_sync_d = {sda_sync_q[0], i_sda};
`ifdef I2C_SLV_SINGLE_BYTE_GLITCH_FILTER_EN
      scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_d = (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                   (scl_hist_q[0] & scl_hist_q[1]);
      sda_filt_d = (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                   (sda_hist_q[0] & sda_hist_q[1]);
      scl_s      = scl_filt_q;
      sda_s      = sda_filt_q;
`else
      scl_s      = scl_sync_q[1];
      sda_s      = sda_sync_q[1];
`endif
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
   end

   // Front end resets to the idle-bus level so reset never fabricates an edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
`ifdef I2C_SLV_SINGLE_BYTE_GLITCH_FILTER_EN
         scl_hist_q <= '1;
         sda_hist_q <= '1;
         scl_filt_q <= 1'b1;
         sda_filt_q <= 1'b1;
`endif
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
`ifdef I2C_SLV_SINGLE_BYTE_GLITCH_FILTER_EN
         scl_hist_q <= scl_hist_d;
         sda_hist_q <= sda_hist_d;
         scl_filt_q <= scl_filt_d;
         sda_filt_q <= sda_filt_d;
`endif
      end
   end

   logic scl_rise, scl_fall, scl_edge, start_det, stop_det;

   always_comb begin
      scl_rise  = scl_s & ~scl_prev_q;
      scl_fall  = ~scl_s & scl_prev_q;
      scl_edge  = scl_rise | scl_fall;
      start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   end

   state_t                   state_q, state_d;
   logic [WIDTH_IDLE_TO-1:0] timer_q, timer_d;
   logic [3:0]               bit_cnt_q, bit_cnt_d;
   logic [7:0]               shift_q, shift_d;
   logic [7:0]               tx_q, tx_d;
   logic                     rw_q, rw_d;
   logic                     sda_q, sda_d;
   logic [7:0]               data_q, data_d;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      rw_d      = rw_q;
      sda_d     = sda_q;
      data_d    = data_q;

      if (stop_det) begin
         state_d = WAIT_FREE;
         sda_d   = 1'b1;
         timer_d = '0;
      end else if (start_det && state_q != WAIT_FREE) begin
         state_d   = ADDR;
         sda_d     = 1'b1;
         timer_d   = '0;
         bit_cnt_d = '0;
         shift_d   = '0;
      end else if (state_q == WAIT_FREE) begin
         if (scl_s && sda_s) begin
            if (timer_q == T_BUF_C) begin
               state_d = IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end else begin
            timer_d = '0;
         end
      end else if (state_q == IDLE) begin
         timer_d = '0;
      end else if (!scl_edge && timer_q == IDLE_TO_C) begin
         state_d = WAIT_FREE;
         sda_d   = 1'b1;
         timer_d = '0;
      end else begin
         timer_d = scl_edge ? '0 : timer_q + 1'b1;
         case (state_q)
            ADDR, WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  if (state_q == WR_DATA) begin
                     state_d = WR_ACK;
                     sda_d   = 1'b0;
                     data_d  = shift_q;
                  end else if (shift_q[7:1] == i_addr) begin
                     state_d = ADDR_ACK;
                     sda_d   = 1'b0;
                     rw_d    = shift_q[0];
                     tx_d    = i_data;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = '0;
                  if (rw_q) begin
                     state_d = RD_DATA;
                     sda_d   = tx_q[7];
                  end else begin
                     state_d = WR_DATA;
                     sda_d   = 1'b1;
                  end
               end
            end
            RD_DATA: begin
               // Each fall moves to the next bit; after bit 0 SDA goes back to the master.
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd7) begin
                     state_d = RD_ACK;
                     sda_d   = 1'b1;
                  end else begin
                     tx_d      = {tx_q[6:0], 1'b1};
                     sda_d     = tx_q[6];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            WR_ACK, RD_ACK: begin
               if (scl_fall) begin
                  state_d = IGNORE;
                  sda_d   = 1'b1;
               end
            end
            IGNORE: sda_d = 1'b1;
            default: begin
               state_d = WAIT_FREE;
               sda_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= WAIT_FREE;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= '0;
         rw_q      <= 1'b0;
         sda_q     <= 1'b1;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         rw_q      <= rw_d;
         sda_q     <= sda_d;
         data_q    <= data_d;
      end
   end

   assign o_sda  = sda_q;
   assign o_data = data_q;

endmodule

// File: tb/tb_i2c_slv_single_byte.sv
// Bench for i2c_slv_single_byte: bit-level I2C master against a transaction-level expectation model.
`timescale 1ns/1ps
module tb_i2c_slv_single_byte;

   localparam logic [6:0] OWN = 7'h51;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [6:0] i_addr = OWN;
   logic [7:0] i_data = 8'h00;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       o_sda;
   logic [7:0] o_data;
   logic       sda_bus;

   assign sda_bus = sda_m & o_sda;

   i2c_slv_single_byte #(.NUM_CLKS_IDLE_TO(800), .NUM_CLKS_T_BUF(80), .WIDTH_IDLE_TO(10)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_addr(i_addr),
      .i_data(i_data),
      .i_scl (scl_m),
      .i_sda (sda_bus),
      .o_sda (o_sda),
      .o_data(o_data)
   );

   always #32 i_clk = ~i_clk;

   int         vectors = 0;
   int         errors  = 0;
   logic [7:0] exp_odata = 8'h00;
   bit         low_seen = 1'b0;
   int         hi_chg = 0;
   logic       sda_prev = 1'b1;

   always @(negedge i_clk) begin
      if (o_sda === 1'b0) low_seen = 1'b1;
      if (!i_rst && scl_m && o_sda !== sda_prev) hi_chg++;
      sda_prev = o_sda;
   end

   initial begin
      #7000000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   task automatic bit_xfer(input bit b, output bit s);
      #500  sda_m = b;
      #4500 scl_m = 1'b1;
      #2350;
      @(negedge i_clk);
      s = sda_bus;
      #2300 scl_m = 1'b0;
   endtask

   task automatic bus_start;
      sda_m = 1'b1;
      scl_m = 1'b1;
      #8000 sda_m = 1'b0;
      #4700 scl_m = 1'b0;
   endtask

   task automatic bus_rstart;
      #500  sda_m = 1'b1;
      #4500 scl_m = 1'b1;
      #2350 sda_m = 1'b0;
      #2350 scl_m = 1'b0;
   endtask

   task automatic bus_stop;
      #500  sda_m = 1'b0;
      #4500 scl_m = 1'b1;
      #4700 sda_m = 1'b1;
      #2000;
   endtask

   task automatic put_byte(input logic [7:0] b, output logic [7:0] seen, output bit ack);
      bit s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(b[i], s);
         seen[i] = s;
      end
      bit_xfer(1'b1, ack);
   endtask

   task automatic get_byte(input bit mack, output logic [7:0] b);
      bit s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         b[i] = s;
      end
      bit_xfer(mack, s);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d, input bit two,
                           output bit aack, output bit dack, output bit xack);
      logic [7:0] seen;
      bus_start;
      put_byte({a, 1'b0}, seen, aack);
      put_byte(d, seen, dack);
      xack = 1'b1;
      if (two) put_byte(8'($urandom), seen, xack);
      bus_stop;
   endtask

   task automatic do_read(input logic [6:0] a, input bit two,
                          output bit aack, output logic [7:0] rd0, output logic [7:0] rd1);
      logic [7:0] seen;
      bus_start;
      put_byte({a, 1'b1}, seen, aack);
      get_byte(!two, rd0);
      rd1 = 8'hFF;
      if (two) get_byte(1'b1, rd1);
      bus_stop;
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      repeat (5) @(posedge i_clk);
      @(negedge i_clk);
      if (o_sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", o_sda); end
      vectors++;
      if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
      vectors++;
      i_rst = 1'b0;
   endtask

   task automatic test_write_nomatch;
      bit aa, da, xa;
      low_seen = 1'b0;
      do_write(7'h52, 8'hAC, 1'b0, aa, da, xa);
      if (aa !== 1'b1) begin errors++; $display("FAIL wr_nomatch_aack: got %b expected 1", aa); end
      vectors++;
      if (da !== 1'b1) begin errors++; $display("FAIL wr_nomatch_dack: got %b expected 1", da); end
      vectors++;
      if (low_seen !== 1'b0) begin errors++; $display("FAIL wr_nomatch_sda: o_sda went low, expected released"); end
      vectors++;
      if (o_data !== exp_odata) begin errors++; $display("FAIL wr_nomatch_data: got %h expected %h", o_data, exp_odata); end
      vectors++;
   endtask

   task automatic test_read_nomatch;
      bit aa;
      logic [7:0] r0, r1;
      i_data = 8'h5A;
      low_seen = 1'b0;
      do_read(7'h52, 1'b0, aa, r0, r1);
      if (aa !== 1'b1) begin errors++; $display("FAIL rd_nomatch_aack: got %b expected 1", aa); end
      vectors++;
      if (r0 !== 8'hFF) begin errors++; $display("FAIL rd_nomatch_data: got %h expected ff", r0); end
      vectors++;
      if (low_seen !== 1'b0) begin errors++; $display("FAIL rd_nomatch_sda: o_sda went low, expected released"); end
      vectors++;
   endtask

   task automatic test_write_match;
      bit aa, da, xa;
      do_write(OWN, 8'h53, 1'b0, aa, da, xa);
      exp_odata = 8'h53;
      if (aa !== 1'b0) begin errors++; $display("FAIL wr_match_aack: got %b expected 0", aa); end
      vectors++;
      if (da !== 1'b0) begin errors++; $display("FAIL wr_match_dack: got %b expected 0", da); end
      vectors++;
      if (o_data !== exp_odata) begin errors++; $display("FAIL wr_match_data: got %h expected %h", o_data, exp_odata); end
      vectors++;
   endtask

   task automatic test_read_match;
      bit aa;
      logic [7:0] seen, r0;
      i_data = 8'h21;
      bus_start;
      put_byte({OWN, 1'b1}, seen, aa);
      if (seen !== 8'hA3) begin errors++; $display("FAIL rd_match_addrbits: got %h expected a3", seen); end
      vectors++;
      if (aa !== 1'b0) begin errors++; $display("FAIL rd_match_aack: got %b expected 0", aa); end
      vectors++;
      get_byte(1'b1, r0);
      if (r0 !== 8'h21) begin errors++; $display("FAIL rd_match_data: got %h expected 21", r0); end
      vectors++;
      #1000;
      @(negedge i_clk);
      if (o_sda !== 1'b1) begin errors++; $display("FAIL rd_match_release: got %b expected 1", o_sda); end
      vectors++;
      bus_stop;
   endtask

   task automatic test_back_to_back;
      bit aa, da, ab;
      logic [7:0] seen, d, r0;
      d = 8'($urandom);
      i_data = 8'($urandom);
      bus_start;
      put_byte({OWN, 1'b0}, seen, aa);
      put_byte(d, seen, da);
      bus_rstart;
      put_byte({OWN, 1'b1}, seen, ab);
      get_byte(1'b1, r0);
      bus_stop;
      exp_odata = d;
      if (aa !== 1'b0 || da !== 1'b0) begin errors++; $display("FAIL b2b_wr_acks: got %b%b expected 00", aa, da); end
      vectors++;
      if (ab !== 1'b0) begin errors++; $display("FAIL b2b_rd_aack: got %b expected 0", ab); end
      vectors++;
      if (r0 !== i_data) begin errors++; $display("FAIL b2b_rd_data: got %h expected %h", r0, i_data); end
      vectors++;
      if (o_data !== exp_odata) begin errors++; $display("FAIL b2b_odata: got %h expected %h", o_data, exp_odata); end
      vectors++;
   endtask

   task automatic test_random;
      for (int n = 0; n < 5; n++) begin
         logic [6:0] a;
         logic [7:0] d, r0, r1;
         bit rw, two, hit, aa, da, xa;
         a   = $urandom_range(0, 1) ? OWN : 7'($urandom);
         rw  = 1'($urandom);
         two = 1'($urandom);
         d   = 8'($urandom);
         i_data = 8'($urandom);
         hit = (a == OWN);
         if (!rw) begin
            do_write(a, d, two, aa, da, xa);
            if (hit) exp_odata = d;
            if (aa !== !hit) begin errors++; $display("FAIL rand%0d_wr_aack: got %b expected %b", n, aa, !hit); end
            vectors++;
            if (da !== !hit) begin errors++; $display("FAIL rand%0d_wr_dack: got %b expected %b", n, da, !hit); end
            vectors++;
            if (xa !== 1'b1) begin errors++; $display("FAIL rand%0d_wr_xack: got %b expected 1", n, xa); end
            vectors++;
            if (o_data !== exp_odata) begin errors++; $display("FAIL rand%0d_wr_data: got %h expected %h", n, o_data, exp_odata); end
            vectors++;
         end else begin
            do_read(a, two, aa, r0, r1);
            if (aa !== !hit) begin errors++; $display("FAIL rand%0d_rd_aack: got %b expected %b", n, aa, !hit); end
            vectors++;
            if (r0 !== (hit ? i_data : 8'hFF)) begin errors++; $display("FAIL rand%0d_rd_data: got %h expected %h", n, r0, hit ? i_data : 8'hFF); end
            vectors++;
            if (r1 !== 8'hFF) begin errors++; $display("FAIL rand%0d_rd_extra: got %h expected ff", n, r1); end
            vectors++;
         end
      end
   endtask

   task automatic test_timeout;
      bit s, aa, da, xa;
      logic [7:0] d;
      logic [7:0] ab;
      ab = {OWN, 1'b0};
      d  = 8'($urandom_range(1, 255));
      bus_start;
      for (int i = 7; i >= 0; i--) bit_xfer(ab[i], s);
      #1000;
      @(negedge i_clk);
      if (o_sda !== 1'b0) begin errors++; $display("FAIL timeout_ack_driven: got %b expected 0", o_sda); end
      vectors++;
      repeat (900) @(posedge i_clk);
      @(negedge i_clk);
      if (o_sda !== 1'b1) begin errors++; $display("FAIL timeout_release: got %b expected 1", o_sda); end
      vectors++;
      bus_stop;
      do_write(OWN, d, 1'b0, aa, da, xa);
      exp_odata = d;
      if (aa !== 1'b0 || da !== 1'b0) begin errors++; $display("FAIL timeout_recover_acks: got %b%b expected 00", aa, da); end
      vectors++;
      if (o_data !== exp_odata) begin errors++; $display("FAIL timeout_recover_data: got %h expected %h", o_data, exp_odata); end
      vectors++;
   endtask

   task automatic test_reset_during_ack;
      bit s, aa, da, xa;
      logic [7:0] ab;
      ab = {OWN, 1'b0};
      bus_start;
      for (int i = 7; i >= 0; i--) bit_xfer(ab[i], s);
      #1000;
      @(negedge i_clk);
      if (o_sda !== 1'b0) begin errors++; $display("FAIL rst_ack_pre: got %b expected 0", o_sda); end
      vectors++;
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      exp_odata = 8'h00;
      if (o_sda !== 1'b1) begin errors++; $display("FAIL rst_ack_sda: got %b expected 1", o_sda); end
      vectors++;
      if (o_data !== exp_odata) begin errors++; $display("FAIL rst_ack_data: got %h expected 00", o_data); end
      vectors++;
      @(negedge i_clk);
      i_rst = 1'b0;
      bit_xfer(1'b1, s);
      bus_stop;
      do_write(OWN, 8'hC3, 1'b0, aa, da, xa);
      exp_odata = 8'hC3;
      if (o_data !== exp_odata) begin errors++; $display("FAIL rst_recover_data: got %h expected %h", o_data, exp_odata); end
      vectors++;
   endtask

   initial begin
      test_reset;
      test_write_nomatch;
      test_read_nomatch;
      test_write_match;
      test_read_match;
      test_back_to_back;
      test_random;
      test_timeout;
      test_reset_during_ack;
      if (hi_chg !== 0) begin errors++; $display("FAIL sda_stable_scl_high: got %0d changes expected 0", hi_chg); end
      vectors++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
